// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI mode-0 target.
//   spi_byte_t     one SPI byte
//   spi_state_e    frame state: IDLE (deselected) / ACTIVE (selected)
//   SPI_IDLE_BYTE  byte shifted out on MISO when nothing is queued to send
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam spi_byte_t SPI_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_if.sv
// -----------------------------------------------------------------------------
// spi_target_if
// Bundles the SPI pins and the local byte-stream handshakes of spi_target.
//   slave  : view used by spi_target (pins in, MISO out, tx consumer, rx producer)
//   master : view used by whatever drives the pins and the byte streams
// Signals:
//   spi_clk, spi_cs_n, spi_mosi   pins from the SPI initiator (asynchronous)
//   spi_miso, spi_miso_en         MISO data and output enable
//   tx_data, tx_valid, tx_ready   bytes to send; tx_ready pulses on consumption
//   rx_data, rx_valid, rx_ready   received bytes; valid held until ready
//   rx_overrun, tx_underrun       1-cycle error pulses
//   frame_end                     1-cycle pulse when chip select is released
//   busy                          high while a frame is active
// -----------------------------------------------------------------------------
interface spi_target_if;
    import spi_pkg::*;

    logic      spi_clk;
    logic      spi_cs_n;
    logic      spi_mosi;
    logic      spi_miso;
    logic      spi_miso_en;
    spi_byte_t tx_data;
    logic      tx_valid;
    logic      tx_ready;
    spi_byte_t rx_data;
    logic      rx_valid;
    logic      rx_ready;
    logic      rx_overrun;
    logic      tx_underrun;
    logic      frame_end;
    logic      busy;

    modport slave (
        input  spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
        output spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid,
               rx_overrun, tx_underrun, frame_end, busy
    );

    modport master (
        output spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
        input  spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid,
               rx_overrun, tx_underrun, frame_end, busy
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
// Small receive FIFO used when SPI_TARGET_RX_FIFO_EN is defined.
//   clock      in  system clock
//   reset_n    in  synchronous active-low reset
//   push       in  write push_data (ignored when full unless popping too)
//   push_data  in  byte to store
//   pop        in  consumer accepts head (ignored when empty)
//   head       out oldest stored byte
//   empty      out no bytes stored
//   full       out DEPTH bytes stored
// Pointers carry one extra wrap bit to tell full from empty.
// -----------------------------------------------------------------------------
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push,
    input  spi_byte_t push_data,
    input  logic      pop,
    output spi_byte_t head,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    spi_byte_t   mem_q [DEPTH];
    spi_byte_t   mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync_bit / spi_sync
// spi_sync_bit : STAGES-flop synchroniser for one asynchronous input.
//   clock  in  system clock
//   din    in  asynchronous input
//   dout   out synchronised level
// spi_sync     : spi_sync_bit plus one extra registered copy for edge detect.
//   clock  in  system clock
//   din    in  asynchronous input
//   rise   out 1 for one cycle after the synchronised level goes 0->1
//   fall   out 1 for one cycle after the synchronised level goes 1->0
// The chains are deliberately not reset: they keep tracking the pins while
// the rest of the block is held in reset, so releasing reset with a pin
// already low (e.g. CS held asserted) never manufactures a false edge.
// -----------------------------------------------------------------------------
module spi_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
    end

    always_ff @(posedge clock) begin
        chain_q <= chain_d;
    end

    assign dout = chain_q[STAGES-1];

endmodule

module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic level;
    logic prev_q;
    logic prev_d;

    spi_sync_bit #(.STAGES(STAGES)) u_bit (
        .clock (clock),
        .din   (din),
        .dout  (level)
    );

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clock) begin
        prev_q <= prev_d;
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
// SPI mode-0 (CPOL=0, CPHA=0) target. SCLK, CS and MOSI are oversampled in the
// local clock domain; MOSI is shifted in MSB first on SCLK rise, MISO is
// shifted out MSB first and advanced on SCLK fall. The system clock must be at
// least 8x SCLK because a pin edge takes SYNC_STAGES+1 cycles to act on and
// MISO settles SYNC_STAGES+2 cycles after an SCLK fall.
// Parameters:
//   SYNC_STAGES    flops per input synchroniser (>=2)
//   IDLE_BYTE      byte sent when no tx byte is queued
//   RX_FIFO_DEPTH  receive FIFO entries, power of two (FIFO build only)
// Build option:
//   SPI_TARGET_RX_FIFO_EN  defined   -> received bytes queue in spi_rx_fifo;
//                                       a byte arriving on full is dropped
//                          undefined -> single rx register; an unaccepted
//                                       byte is overwritten by the next one
// Ports:
//   clock      in  system clock
//   reset_n    in  synchronous active-low reset
//   bus        spi_target_if.slave: pins, tx/rx byte handshakes, status pulses
//
// state  | meaning
// IDLE   | deselected; SCLK ignored, MISO disabled (driven 1)
// ACTIVE | CS asserted; shifting bytes in and out
// -----------------------------------------------------------------------------
module spi_target
    import spi_pkg::*;
#(
    parameter int        SYNC_STAGES   = 2,
    parameter spi_byte_t IDLE_BYTE     = SPI_IDLE_BYTE,
    parameter int        RX_FIFO_DEPTH = 4
) (
    input logic         clock,
    input logic         reset_n,
    spi_target_if.slave bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("spi_target: SYNC_STAGES must be at least 2");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("spi_target: RX_FIFO_DEPTH must be a power of two, at least 2");
    end

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic mosi_sync;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock (clock),
        .din   (bus.spi_clk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clock (clock),
        .din   (bus.spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock (clock),
        .din   (bus.spi_mosi),
        .dout  (mosi_sync)
    );

    spi_state_e state_q, state_d;
    spi_byte_t  shift_tx_q, shift_tx_d;
    spi_byte_t  shift_rx_q, shift_rx_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rx_commit_q, rx_commit_d;
    logic       miso_q, miso_d;
    logic       miso_en_q, miso_en_d;
    logic       frame_end_q, frame_end_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       load_tx;
    spi_byte_t  tx_next;

    assign tx_next = bus.tx_valid ? bus.tx_data : IDLE_BYTE;

    always_comb begin
        state_d     = state_q;
        shift_tx_d  = shift_tx_q;
        shift_rx_d  = shift_rx_q;
        bit_cnt_d   = bit_cnt_q;
        rx_commit_d = 1'b0;
        miso_d      = miso_q;
        miso_en_d   = miso_en_q;
        frame_end_d = 1'b0;
        load_tx     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    load_tx    = 1'b1;
                    bit_cnt_d  = '0;
                    shift_rx_d = '0;
                    miso_en_d  = 1'b1;
                end
            end
            ACTIVE: begin
                // CS release wins over any SCLK edge seen in the same cycle;
                // partial bytes in both directions are abandoned.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_rx_d  = '0;
                    miso_en_d   = 1'b0;
                    miso_d      = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx_d = {shift_rx_q[6:0], mosi_sync};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_commit_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // bit_cnt==0 on a fall means the 8th rise just wrapped it:
                    // the byte is done and the next one is loaded.
                    if (bit_cnt_q != 3'd0) begin
                        shift_tx_d = {shift_tx_q[6:0], 1'b0};
                        miso_d     = shift_tx_q[6];
                    end else begin
                        load_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_tx) begin
            shift_tx_d = tx_next;
            miso_d     = tx_next[7];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_tx_q   <= IDLE_BYTE;
            shift_rx_q   <= '0;
            bit_cnt_q    <= '0;
            rx_commit_q  <= 1'b0;
            miso_q       <= 1'b1;
            miso_en_q    <= 1'b0;
            frame_end_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_tx_q   <= shift_tx_d;
            shift_rx_q   <= shift_rx_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_commit_q  <= rx_commit_d;
            miso_q       <= miso_d;
            miso_en_q    <= miso_en_d;
            frame_end_q  <= frame_end_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    // tx_ready/tx_underrun are strobes in the very cycle tx_data is sampled,
    // so a producer advancing on tx_ready never loses or repeats a byte.
    assign bus.tx_ready    = reset_n && load_tx && bus.tx_valid;
    assign bus.tx_underrun = reset_n && load_tx && !bus.tx_valid;
    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_en = miso_en_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.busy        = (state_q == ACTIVE);

`ifdef SPI_TARGET_RX_FIFO_EN

    logic      fifo_empty;
    logic      fifo_full;
    spi_byte_t fifo_head;

    spi_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rx_commit_q),
        .push_data (shift_rx_q),
        .pop       (bus.rx_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // full implies non-empty, so only a missing rx_ready blocks the push.
    assign rx_overrun_d = rx_commit_q && fifo_full && !bus.rx_ready;
    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_data  = fifo_head;

`else

    spi_byte_t rx_data_q, rx_data_d;
    logic      rx_valid_q, rx_valid_d;

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = 1'b0;
        if (rx_commit_q) begin
            // A byte still pending and not taken this cycle is lost.
            rx_data_d    = shift_rx_q;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q && !bus.rx_ready;
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

`endif

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
// Drives spi_target as a mode-0 initiator. Expected received bytes go into a
// queue when they are sent; a monitor pops and compares on every rx handshake
// and counts status pulses. MISO bytes and pulse counts are checked by the
// stimulus against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_target;

    localparam int H = 6;   // SCLK half period in system clocks (12x ratio)

    logic clk;
    logic rst_n;

    spi_target_if bus_if ();

    spi_target dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    int n_tx_ready  = 0;
    int n_underrun  = 0;
    int n_overrun   = 0;
    int n_frame_end = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: rx scoreboard and pulse counters, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.tx_ready)    n_tx_ready++;
                if (bus_if.tx_underrun) n_underrun++;
                if (bus_if.rx_overrun)  n_overrun++;
                if (bus_if.frame_end)   n_frame_end++;
                if (bus_if.rx_valid && bus_if.rx_ready) begin
                    if (exp_rx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: got %02h with no byte expected", bus_if.rx_data);
                    end else begin
                        check("rx_data", int'(bus_if.rx_data), int'(exp_rx.pop_front()));
                    end
                end
            end
        end
    end

    // Tx producer: presents the head of tx_q, advances after a tx_ready strobe.
    initial begin
        logic took;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            took = bus_if.tx_ready;
            @(posedge clk);
            #1;
            if (took && tx_q.size() > 0) void'(tx_q.pop_front());
            bus_if.tx_valid = (tx_q.size() > 0);
            bus_if.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        bus_if.spi_cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high();
        cyc(H);
        bus_if.spi_cs_n = 1'b1;
        cyc(8);
    endtask

    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus_if.spi_mosi = mo[7-i];
            cyc(H);
            bus_if.spi_clk = 1'b1;
            mi = {mi[6:0], bus_if.spi_miso};
            cyc(H);
            bus_if.spi_clk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] mi;
        int s_txr, s_und, s_ovr, s_fe;
        int en_bad;

        rst_n           = 1'b0;
        bus_if.spi_clk  = 1'b0;
        bus_if.spi_cs_n = 1'b1;
        bus_if.spi_mosi = 1'b0;
        bus_if.rx_ready = 1'b1;
        cyc(6);

        check("rst_miso",        int'(bus_if.spi_miso),    1);
        check("rst_miso_en",     int'(bus_if.spi_miso_en), 0);
        check("rst_tx_ready",    int'(bus_if.tx_ready),    0);
        check("rst_rx_valid",    int'(bus_if.rx_valid),    0);
        check("rst_rx_data",     int'(bus_if.rx_data),     0);
        check("rst_busy",        int'(bus_if.busy),        0);
        check("rst_frame_end",   int'(bus_if.frame_end),   0);
        check("rst_tx_underrun", int'(bus_if.tx_underrun), 0);
        rst_n = 1'b1;
        cyc(4);

        // 1: one byte each way
        tx_q.push_back(8'h3C);
        exp_rx.push_back(8'hA5);
        cyc(3);
        s_txr = n_tx_ready; s_und = n_underrun; s_fe = n_frame_end;
        cs_low();
        check("t1_busy",    int'(bus_if.busy),        1);
        check("t1_miso_en", int'(bus_if.spi_miso_en), 1);
        xfer_bits(8'hA5, 8, mi);
        check("t1_miso_byte", int'(mi), 'h3C);
        cs_high();
        check("t1_frame_end",  n_frame_end - s_fe, 1);
        check("t1_tx_ready",   n_tx_ready - s_txr, 1);
        // Reload after the last SCLK fall finds no byte queued.
        check("t1_underrun",   n_underrun - s_und, 1);
        check("t1_miso_en_off", int'(bus_if.spi_miso_en), 0);
        check("t1_miso_idle",   int'(bus_if.spi_miso),    1);
        check("t1_busy_off",    int'(bus_if.busy),        0);

        // 2: three bytes, nothing to send
        exp_rx.push_back(8'h5A);
        exp_rx.push_back(8'h01);
        exp_rx.push_back(8'h80);
        s_und = n_underrun;
        cs_low();
        xfer_bits(8'h5A, 8, mi);
        check("t2_miso_b0", int'(mi), 'hFF);
        xfer_bits(8'h01, 8, mi);
        check("t2_miso_b1", int'(mi), 'hFF);
        xfer_bits(8'h80, 8, mi);
        check("t2_miso_b2", int'(mi), 'hFF);
        cs_high();
        // CS-fall load, two inter-byte reloads, plus the reload after the last fall.
        check("t2_underrun", n_underrun - s_und, 4);

        // 3: two bytes while the consumer stalls
        bus_if.rx_ready = 1'b0;
        s_ovr = n_overrun;
        cs_low();
        xfer_bits(8'h11, 8, mi);
        xfer_bits(8'h22, 8, mi);
        cs_high();
        cyc(4);
        check("t3_rx_valid", int'(bus_if.rx_valid), 1);
`ifdef SPI_TARGET_RX_FIFO_EN
        check("t3_overrun", n_overrun - s_ovr, 0);
        check("t3_rx_head", int'(bus_if.rx_data), 'h11);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
`else
        check("t3_overrun", n_overrun - s_ovr, 1);
        check("t3_rx_head", int'(bus_if.rx_data), 'h22);
        exp_rx.push_back(8'h22);
`endif
        bus_if.rx_ready = 1'b1;
        cyc(6);

        // 4: frame aborted after five SCLK rises, then a clean byte
        s_fe = n_frame_end;
        cs_low();
        xfer_bits(8'hE8, 5, mi);
        cs_high();
        check("t4_frame_end",  n_frame_end - s_fe, 1);
        check("t4_miso_en",    int'(bus_if.spi_miso_en), 0);
        check("t4_miso_idle",  int'(bus_if.spi_miso),    1);
        check("t4_no_rx",      int'(bus_if.rx_valid),    0);
        tx_q.push_back(8'h69);
        exp_rx.push_back(8'h96);
        cyc(3);
        cs_low();
        xfer_bits(8'h96, 8, mi);
        check("t4_miso_byte", int'(mi), 'h69);
        cs_high();

        // 5: reset in the middle of a byte, then a fresh frame
        cs_low();
        xfer_bits(8'h5A, 3, mi);
        rst_n = 1'b0;
        cyc(3);
        check("t5_rst_busy",    int'(bus_if.busy),        0);
        check("t5_rst_miso_en", int'(bus_if.spi_miso_en), 0);
        check("t5_rst_miso",    int'(bus_if.spi_miso),    1);
        rst_n = 1'b1;
        cyc(4);
        check("t5_idle_after_rst", int'(bus_if.busy), 0);
        s_fe = n_frame_end;
        bus_if.spi_cs_n = 1'b1;
        cyc(8);
        check("t5_no_frame_end", n_frame_end - s_fe, 0);
        exp_rx.push_back(8'hC3);
        cs_low();
        xfer_bits(8'hC3, 8, mi);
        cs_high();
        check("t5_frame_end", n_frame_end - s_fe, 1);

        // 6: SCLK toggling while deselected
        tx_q.push_back(8'h77);
        cyc(3);
        s_txr = n_tx_ready;
        en_bad = 0;
        for (int i = 0; i < 16; i++) begin
            bus_if.spi_mosi = i[0];
            cyc(H);
            bus_if.spi_clk = 1'b1;
            if (bus_if.spi_miso_en) en_bad++;
            cyc(H);
            bus_if.spi_clk = 1'b0;
            if (bus_if.spi_miso_en) en_bad++;
        end
        cyc(6);
        check("t6_miso_en",  en_bad, 0);
        check("t6_tx_ready", n_tx_ready - s_txr, 0);
        check("t6_rx_valid", int'(bus_if.rx_valid), 0);
        tx_q.delete();

        cyc(10);
        check("rx_leftover", exp_rx.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
